oclk_sequencer: RTL and testbench
=================================

OCLK_SEQUENCER -- requirements
Module: oclk_sequencer

Interface
REQ-001 Parameter LGDIV, default 8, width of the half-period divider.
REQ-002 Parameter LGCOUNT, default 8, width of the burst clock-count.
REQ-003 Parameter CPOL, default 1'b0, idle level of the output clock.
REQ-004 i_clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 i_reset_n  input  1  synchronous, active-low reset.
REQ-006 i_stb  input  1  burst request, accepted only when o_busy is low.
REQ-007 i_div  input  LGDIV  half-period in i_clk cycles; 0 selects full-rate DDR clock.
REQ-008 i_count  input  LGCOUNT  number of output clock cycles in the burst.
REQ-009 o_busy  output  1  burst in progress.
REQ-010 o_done  output  1  one-cycle pulse at burst end.
REQ-011 o_edge  output  1  one-cycle pulse marking each leading output-clock edge.
REQ-012 o_ddr  output  2  DDR pattern for the pin driver; [1] is the first half-cycle and [0] the second.

Function
REQ-013 States IDLE and RUN; IDLE->RUN on i_stb && !o_busy with i_count!=0; RUN->IDLE after the final pattern cycle.
REQ-014 On acceptance at edge t, i_div and i_count SHALL be latched; later changes are ignored until the next acceptance.
REQ-015 o_ddr, o_busy, o_edge and o_done SHALL be registered; the first burst pattern appears at t+1, when o_busy also rises.
REQ-016 IDLE: o_ddr = {CPOL,CPOL}.
REQ-017 div=0: each RUN cycle o_ddr = {~CPOL,CPOL}, with one output clock per i_clk cycle.
REQ-018 div=N>0: o_ddr = {~CPOL,~CPOL} for N cycles, then {CPOL,CPOL} for N cycles, per output clock.
REQ-019 Burst length SHALL be count*(div==0 ? 1 : 2*div) RUN cycles exactly, with no runt or stretched half-periods.
REQ-020 o_edge SHALL be high on exactly the cycles whose o_ddr carries a leading (away-from-idle) edge: count pulses per burst.
REQ-021 o_done SHALL pulse on the cycle after the last pattern cycle, with o_busy low in that same cycle.
REQ-022 A new i_stb SHALL be accepted in the o_done cycle, giving a minimum one-cycle idle gap between bursts.
REQ-023 i_count=0: request accepted, no pattern cycles, o_busy stays low, and o_done pulses at t+1.
REQ-024 i_stb while o_busy is high SHALL be ignored and not queued.
REQ-025 Counters SHALL be LGDIV and LGCOUNT bits wide; the maximum div (2^LGDIV-1) and count (2^LGCOUNT-1) SHALL work without wrap.

Reset
REQ-026 When i_reset_n is low at an edge, the next cycle SHALL show o_ddr={CPOL,CPOL}, o_busy=0, o_done=0, o_edge=0, state IDLE, and counters zero.
REQ-027 A reset during RUN SHALL abandon the burst with no o_done pulse.

Configuration
REQ-028 Macro OCLK_SEQUENCER_ABORT_EN, when defined, SHALL add input i_abort (1 bit).
REQ-029 With the macro defined, i_abort high in RUN SHALL complete the current output clock cycle (both halves), discard the remaining count, and then pulse o_done normally.
REQ-030 With the macro defined, i_abort SHALL be ignored in IDLE and in the accept cycle.
REQ-031 Without the macro, the i_abort port SHALL be absent and bursts always run to completion.

Verification
REQ-032 CPOL=0, i_div=0, i_count=4 -> o_ddr=10 for 4 cycles, o_edge high for 4 cycles, o_done pulses at t+5.
REQ-033 CPOL=0, i_div=2, i_count=3 -> 12 RUN cycles with pattern 11,11,00,00 repeated; o_edge on RUN cycles 1, 5 and 9.
REQ-034 CPOL=1, i_div=1, i_count=2 -> o_ddr sequence 00,11,00,11 then idle 11; o_done follows.
REQ-035 i_stb in the o_done cycle with i_count=1 and i_div=0 -> second burst starts the next cycle; i_stb during o_busy produces no extra burst.
REQ-036 i_reset_n low at RUN cycle 3 of a div=1, count=5 burst -> idle pattern next cycle, no o_done.
REQ-037 (OCLK_SEQUENCER_ABORT_EN) i_div=2, i_count=10, i_abort in RUN cycle 2 -> exactly 4 RUN cycles, 1 o_edge, then o_done.

Source files
------------

// File: rtl/oclk_sequencer.sv
// rtl/oclk_sequencer.sv - burst output-clock generator driving a 2-bit DDR pin pattern
// Defining OCLK_SEQUENCER_ABORT_EN adds i_abort to cut a burst short at the next output-clock boundary.
module oclk_sequencer #(
  parameter int   LGDIV   = 8,
  parameter int   LGCOUNT = 8,
  parameter logic CPOL    = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_stb,
  input  logic [LGDIV-1:0]   i_div,
  input  logic [LGCOUNT-1:0] i_count,
`ifdef OCLK_SEQUENCER_ABORT_EN
  input  logic               i_abort,
`endif
  output logic               o_busy,
  output logic               o_done,
  output logic               o_edge,
  output logic [1:0]         o_ddr
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] PAT_IDLE   = {CPOL, CPOL};
  localparam logic [1:0] PAT_ACTIVE = {~CPOL, ~CPOL};
  localparam logic [1:0] PAT_DDR    = {~CPOL, CPOL};

  state_t               state_q, state_d;
  logic [LGDIV-1:0]     div_q, div_d;
  logic [LGDIV-1:0]     tick_q, tick_d;
  logic [LGCOUNT-1:0]   left_q, left_d;
  logic                 phase_q, phase_d;
  logic                 abort_q, abort_d;
  logic [1:0]           ddr_d;
  logic                 busy_d, done_d, edge_d;

  logic                 abort_in;
  logic                 abort_pend;
  logic                 div_zero;
  logic                 half_end;
  logic                 clk_end;
  logic                 last_clk;

`ifdef OCLK_SEQUENCER_ABORT_EN
  assign abort_in = i_abort;
`else
  assign abort_in = 1'b0;
`endif

  // tick_q counts i_clk cycles within the current half-period; phase_q=1 is the idle-level half.
  // left_q holds the output clocks still to finish, including the one on the pin now.
  assign abort_pend = abort_q || abort_in;
  assign div_zero   = (div_q == '0);
  assign half_end   = (tick_q == div_q - LGDIV'(1));
  assign clk_end    = div_zero || (phase_q && half_end);
  assign last_clk   = (left_q == LGCOUNT'(1)) || abort_pend;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      tick_q  <= '0;
      left_q  <= '0;
      phase_q <= 1'b0;
      abort_q <= 1'b0;
      o_ddr   <= PAT_IDLE;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_edge  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      left_q  <= left_d;
      phase_q <= phase_d;
      abort_q <= abort_d;
      o_ddr   <= ddr_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
      o_edge  <= edge_d;
    end
  end

  // Every output is a registered copy of what this block decides for the next cycle.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tick_d  = tick_q;
    left_d  = left_q;
    phase_d = phase_q;
    abort_d = abort_q;
    ddr_d   = PAT_IDLE;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    edge_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_stb) begin
          div_d   = i_div;
          left_d  = i_count;
          tick_d  = '0;
          phase_d = 1'b0;
          abort_d = 1'b0;
          if (i_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            edge_d  = 1'b1;
            ddr_d   = (i_div == '0) ? PAT_DDR : PAT_ACTIVE;
          end
        end
      end

      RUN: begin
        busy_d  = 1'b1;
        abort_d = abort_pend;
        if (clk_end && last_clk) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          left_d  = '0;
          tick_d  = '0;
          phase_d = 1'b0;
          abort_d = 1'b0;
        end else if (clk_end) begin
          left_d  = left_q - LGCOUNT'(1);
          tick_d  = '0;
          phase_d = 1'b0;
          edge_d  = 1'b1;
          ddr_d   = div_zero ? PAT_DDR : PAT_ACTIVE;
        end else if (half_end) begin
          tick_d  = '0;
          phase_d = 1'b1;
          ddr_d   = PAT_IDLE;
        end else begin
          tick_d  = tick_q + LGDIV'(1);
          ddr_d   = phase_q ? PAT_IDLE : PAT_ACTIVE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_oclk_sequencer.sv
// tb/tb_oclk_sequencer.sv - self-checking bench for oclk_sequencer
// Two instances share stimulus: default widths with CPOL=0, and 3-bit widths with CPOL=1.
module tb_oclk_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       stb;
  logic [7:0] div;
  logic [7:0] cnt;
`ifdef OCLK_SEQUENCER_ABORT_EN
  logic       abort;
`endif
  logic       busy0, done0, edge0;
  logic [1:0] ddr0;
  logic       busy1, done1, edge1;
  logic [1:0] ddr1;
  logic [4:0] e0, e1;
  int         n_cmp  = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  oclk_sequencer dut0 (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_stb     (stb),
    .i_div     (div),
    .i_count   (cnt),
`ifdef OCLK_SEQUENCER_ABORT_EN
    .i_abort   (abort),
`endif
    .o_busy    (busy0),
    .o_done    (done0),
    .o_edge    (edge0),
    .o_ddr     (ddr0)
  );

  oclk_sequencer #(.LGDIV(3), .LGCOUNT(3), .CPOL(1'b1)) dut1 (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_stb     (stb),
    .i_div     (div[2:0]),
    .i_count   (cnt[2:0]),
`ifdef OCLK_SEQUENCER_ABORT_EN
    .i_abort   (abort),
`endif
    .o_busy    (busy1),
    .o_done    (done1),
    .o_edge    (edge1),
    .o_ddr     (ddr1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int blen(int d, int c);
    return c * ((d == 0) ? 1 : 2 * d);
  endfunction

  // Expected {busy, done, edge, ddr} at cycle k after the accepting edge (k=0 is t+1).
  function automatic logic [4:0] exp_out(int d, int c, logic p, int k);
    int per;
    per = (d == 0) ? 1 : 2 * d;
    if (k < c * per) begin
      if (d == 0) return {1'b1, 1'b0, 1'b1, ~p, p};
      if ((k % per) < d) return {1'b1, 1'b0, ((k % per) == 0), ~p, ~p};
      return {1'b1, 1'b0, 1'b0, p, p};
    end
    if (k == c * per) return {1'b0, 1'b1, 1'b0, p, p};
    return {1'b0, 1'b0, 1'b0, p, p};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    stb = 1'b0;
    div = '0;
    cnt = '0;
`ifdef OCLK_SEQUENCER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      n_cmp += 2;
      if ({busy0, done0, edge0, ddr0} !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset[%0d] cpol0 got=%b want=00000", i, {busy0, done0, edge0, ddr0});
      end
      if ({busy1, done1, edge1, ddr1} !== 5'b00011) begin
        n_fail++;
        $display("FAIL reset[%0d] cpol1 got=%b want=00011", i, {busy1, done1, edge1, ddr1});
      end
      reset_n = 1'b1;
      step();
    end
  endtask

  task automatic test_directed();
    int td[4] = '{0, 2, 1, 0};
    int tc[4] = '{4, 3, 2, 0};
    for (int i = 0; i < 4; i++) begin
      div = td[i][7:0];
      cnt = tc[i][7:0];
      stb = 1'b1;
      step();
      stb = 1'b0;
      for (int k = 0; k <= blen(td[i], tc[i]) + 2; k++) begin
        e0 = exp_out(td[i], tc[i], 1'b0, k);
        e1 = exp_out(td[i], tc[i], 1'b1, k);
        n_cmp += 2;
        if ({busy0, done0, edge0, ddr0} !== e0) begin
          n_fail++;
          $display("FAIL directed[%0d] cpol0 k=%0d got=%b want=%b", i, k, {busy0, done0, edge0, ddr0}, e0);
        end
        if ({busy1, done1, edge1, ddr1} !== e1) begin
          n_fail++;
          $display("FAIL directed[%0d] cpol1 k=%0d got=%b want=%b", i, k, {busy1, done1, edge1, ddr1}, e1);
        end
        step();
      end
    end
  endtask

  // Requests and input changes during a burst must be ignored; the burst uses the latched values.
  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int d, c, len;
      d = $urandom_range(0, 7);
      c = $urandom_range(0, 7);
      len = blen(d, c);
      div = d[7:0];
      cnt = c[7:0];
      stb = 1'b1;
      step();
      stb = 1'b0;
      for (int k = 0; k <= len + 1; k++) begin
        e0 = exp_out(d, c, 1'b0, k);
        e1 = exp_out(d, c, 1'b1, k);
        n_cmp += 2;
        if ({busy0, done0, edge0, ddr0} !== e0) begin
          n_fail++;
          $display("FAIL random[%0d] d=%0d c=%0d cpol0 k=%0d got=%b want=%b", n, d, c, k, {busy0, done0, edge0, ddr0}, e0);
        end
        if ({busy1, done1, edge1, ddr1} !== e1) begin
          n_fail++;
          $display("FAIL random[%0d] d=%0d c=%0d cpol1 k=%0d got=%b want=%b", n, d, c, k, {busy1, done1, edge1, ddr1}, e1);
        end
        if (k < len) begin
          stb = 1'($urandom_range(0, 1));
          div = 8'($urandom);
          cnt = 8'($urandom);
        end else begin
          stb = 1'b0;
        end
        step();
      end
    end
  endtask

  // A request in the done cycle starts the next burst at once; one held during busy adds nothing.
  task automatic test_back_to_back();
    int d[3]    = '{0, 0, 1};
    int c[3]    = '{1, 1, 3};
    int start   = 0;
    int b       = 0;
    div = 8'd0;
    cnt = 8'd1;
    stb = 1'b1;
    step();
    for (int k = 0; k < 20; k++) begin
      e0 = exp_out(d[b], c[b], 1'b0, k - start);
      e1 = exp_out(d[b], c[b], 1'b1, k - start);
      n_cmp += 2;
      if ({busy0, done0, edge0, ddr0} !== e0) begin
        n_fail++;
        $display("FAIL b2b burst=%0d cpol0 k=%0d got=%b want=%b", b, k, {busy0, done0, edge0, ddr0}, e0);
      end
      if ({busy1, done1, edge1, ddr1} !== e1) begin
        n_fail++;
        $display("FAIL b2b burst=%0d cpol1 k=%0d got=%b want=%b", b, k, {busy1, done1, edge1, ddr1}, e1);
      end
      if (b < 2 && k - start == blen(d[b], c[b])) begin
        b++;
        start = k + 1;
        div = d[b][7:0];
        cnt = c[b][7:0];
        stb = 1'b1;
      end else begin
        stb = (b == 2 && k - start < blen(d[b], c[b]));
      end
      step();
    end
    stb = 1'b0;
  endtask

  task automatic test_max();
    int td[3] = '{255, 0, 7};
    int tc[3] = '{1, 255, 7};
    for (int i = 0; i < 3; i++) begin
      int len0, len1, kmax;
      len0 = blen(td[i], tc[i]);
      len1 = blen(td[i] % 8, tc[i] % 8);
      kmax = (len0 > len1 ? len0 : len1) + 1;
      div = td[i][7:0];
      cnt = tc[i][7:0];
      stb = 1'b1;
      step();
      stb = 1'b0;
      for (int k = 0; k <= kmax; k++) begin
        e0 = exp_out(td[i], tc[i], 1'b0, k);
        e1 = exp_out(td[i] % 8, tc[i] % 8, 1'b1, k);
        n_cmp += 2;
        if ({busy0, done0, edge0, ddr0} !== e0) begin
          n_fail++;
          $display("FAIL max[%0d] cpol0 k=%0d got=%b want=%b", i, k, {busy0, done0, edge0, ddr0}, e0);
        end
        if ({busy1, done1, edge1, ddr1} !== e1) begin
          n_fail++;
          $display("FAIL max[%0d] cpol1 k=%0d got=%b want=%b", i, k, {busy1, done1, edge1, ddr1}, e1);
        end
        step();
      end
    end
  endtask

  task automatic test_reset_mid();
    div = 8'd1;
    cnt = 8'd5;
    stb = 1'b1;
    step();
    stb = 1'b0;
    for (int k = 0; k < 14; k++) begin
      e0 = (k < 3) ? exp_out(1, 5, 1'b0, k) : 5'b00000;
      e1 = (k < 3) ? exp_out(1, 5, 1'b1, k) : 5'b00011;
      n_cmp += 2;
      if ({busy0, done0, edge0, ddr0} !== e0) begin
        n_fail++;
        $display("FAIL reset_mid cpol0 k=%0d got=%b want=%b", k, {busy0, done0, edge0, ddr0}, e0);
      end
      if ({busy1, done1, edge1, ddr1} !== e1) begin
        n_fail++;
        $display("FAIL reset_mid cpol1 k=%0d got=%b want=%b", k, {busy1, done1, edge1, ddr1}, e1);
      end
      reset_n = (k != 2);
      step();
    end
    reset_n = 1'b1;
  endtask

`ifdef OCLK_SEQUENCER_ABORT_EN
  // Abort finishes the output clock in progress, so the effective count is the clocks started so far.
  task automatic test_abort();
    int td[3] = '{2, 0, 1};
    int tc[3] = '{10, 7, 2};
    int ta[3] = '{1, 3, -1};
    abort = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      int per, ceff;
      per = (td[i] == 0) ? 1 : 2 * td[i];
      ceff = (ta[i] < 0) ? tc[i] : ta[i] / per + 1;
      div = td[i][7:0];
      cnt = tc[i][7:0];
      stb = 1'b1;
      abort = 1'b1;
      step();
      stb = 1'b0;
      abort = 1'b0;
      for (int k = 0; k <= blen(td[i], ceff) + 2; k++) begin
        e0 = exp_out(td[i], ceff, 1'b0, k);
        e1 = exp_out(td[i], ceff, 1'b1, k);
        n_cmp += 2;
        if ({busy0, done0, edge0, ddr0} !== e0) begin
          n_fail++;
          $display("FAIL abort[%0d] cpol0 k=%0d got=%b want=%b", i, k, {busy0, done0, edge0, ddr0}, e0);
        end
        if ({busy1, done1, edge1, ddr1} !== e1) begin
          n_fail++;
          $display("FAIL abort[%0d] cpol1 k=%0d got=%b want=%b", i, k, {busy1, done1, edge1, ddr1}, e1);
        end
        abort = (k == ta[i]);
        step();
      end
      abort = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_max();
    test_reset_mid();
`ifdef OCLK_SEQUENCER_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
